status_flag_unit: RTL
=====================

// Module: status_flag_unit
// PURPOSE
//  Producer side of the NZCV status interface: builds and holds the 4-bit status register
//  consumed by the ID-stage condition checker. Flags come from EXE-stage ALU results, or from
//  the multi-cycle multiplier with a wait state. Provides a bypassed flag view and a hazard
//  stall so no conditional instruction is evaluated against stale flags.
// PARAMETERS
//  DATA_W  32  ALU/multiplier result width
// PORTS
//  clk              in   1       clock; all state updates on rising edge
//  rst_n            in   1       asynchronous reset, active low
//  exe_valid        in   1       instruction valid in EXE this cycle
//  exe_cond_pass    in   1       EXE instruction passed its condition check
//  exe_s            in   1       S bit: instruction updates flags
//  exe_op_class     in   2       00 logical, 01 add, 10 sub, 11 mul
//  exe_result       in   DATA_W  ALU result (ignored for mul)
//  exe_carry        in   1       ALU carry-out (sub: NOT borrow) or shifter carry (logical)
//  exe_overflow     in   1       ALU signed overflow
//  mul_res_valid    in   1       multiplier result valid, single-cycle pulse
//  mul_result       in   DATA_W  multiplier result
//  flush            in   1       pipeline flush (branch taken)
//  id_cond          in   4       condition field of the instruction in ID
//  id_s             in   1       S bit of the instruction in ID
//  status_reg       out  4       registered flags {N,Z,C,V}, N=bit3 .. V=bit0
//  status_fwd       out  4       combinational next flags (bypass for the ID condition checker)
//  flag_stall       out  1       stall request to ID/IF
// BEHAVIOUR
//  - Reset: status_reg=4'b0000, state=IDLE. flag_stall=0 and status_fwd=0000 follow from this state.
//  - upd = exe_valid & exe_cond_pass & exe_s & ~flush.
//  - IDLE, upd, class 00: N=res[DATA_W-1], Z=(res==0), C=exe_carry, V unchanged.
//  - IDLE, upd, class 01/10: N, Z as above; C=exe_carry; V=exe_overflow.
//  - IDLE, upd, class 11: no flag change; go to MUL_WAIT.
//  - MUL_WAIT, mul_res_valid & ~flush: N=mul_result[DATA_W-1], Z=(mul_result==0).
//    C and V unchanged. Go to IDLE.
//  - MUL_WAIT, flush: go to IDLE, no update. Flush wins over a simultaneous mul_res_valid.
//  - In MUL_WAIT, exe_valid with exe_s is a protocol error: ignored, no update.
//    ID is held by flag_stall, so this cannot happen legally.
//  - Latency: status_reg reflects an update 1 cycle after it. status_fwd shows the value in the
//    same cycle (equals status_reg when there is no update).
//  - flag_stall = (state==MUL_WAIT) & ~mul_res_valid & ((id_cond!=4'b1110) | id_s).
//    It drops in the cycle mul_res_valid arrives, because status_fwd already carries the result.
//  - Reset mid-MUL_WAIT: returns immediately to IDLE with status 0000.
//  - Zero detection is a full-width reduction. No arithmetic is done here; C and V are trusted
//    from the ALU.
// STRUCTURE
//  - Shared package: FLAG_N/Z/C/V bit indices; OP_LOGIC/ADD/SUB/MUL class codes;
//    COND_AL=4'b1110; state enum {IDLE, MUL_WAIT}.
//  - One sub-module, flag_gen: combinational N/Z/C/V from result, carry, overflow and class.
//    It is instanced once and fed by a mux selecting the ALU or multiplier result.
// TESTING
//  - Reset: rst_n low mid-run -> status_reg=0000 and flag_stall=0 at once, asynchronous.
//  - SUB, S=1, res=0, carry=1, ovf=0 -> status_fwd=0110 that cycle; status_reg=0110 next cycle.
//  - Logical, S=1, res=32'h8000_0000, carry=0, prior V=1 -> status_reg=1001.
//  - ADD with S=0, or exe_cond_pass=0, res=0 -> status_reg unchanged.
//  - MUL S=1 then id_cond=0000 (EQ) for 3 cycles -> flag_stall=1 for 3 cycles.
//    Then mul_res_valid with mul_result=0, prior C=1 V=0 -> stall=0 that cycle,
//    status_fwd=0110, status_reg=0110 next cycle.
//  - MUL_WAIT with flush and mul_res_valid in the same cycle -> state IDLE, flags unchanged.
//    With id_cond=1110 and id_s=0 during MUL_WAIT -> flag_stall=0.

Source files
------------

// File: rtl/status_flag_unit_pkg.sv
// Shared definitions for the NZCV status flag unit: flag bit positions,
// EXE operation class codes, the "always" condition code and the FSM states.
package status_flag_unit_pkg;

  // Bit positions inside the 4-bit {N,Z,C,V} status word.
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // EXE operation classes.
  localparam logic [1:0] OP_LOGIC = 2'b00;
  localparam logic [1:0] OP_ADD   = 2'b01;
  localparam logic [1:0] OP_SUB   = 2'b10;
  localparam logic [1:0] OP_MUL   = 2'b11;

  // Condition field meaning "always execute".
  localparam logic [3:0] COND_AL = 4'b1110;

  typedef enum logic {
    IDLE     = 1'b0,
    MUL_WAIT = 1'b1
  } state_t;

endpackage

// File: rtl/status_flag_unit_if.sv
// Bus between the EXE/ID pipeline stages and the status flag unit.
//   slave  : flag unit side (consumes EXE/multiplier/ID info, drives flags/stall)
//   master : pipeline side (drives EXE/multiplier/ID info, consumes flags/stall)
interface status_flag_unit_if #(
  parameter int DATA_W = 32
);
  logic              exe_valid;
  logic              exe_cond_pass;
  logic              exe_s;
  logic [1:0]        exe_op_class;
  logic [DATA_W-1:0] exe_result;
  logic              exe_carry;
  logic              exe_overflow;
  logic              mul_res_valid;
  logic [DATA_W-1:0] mul_result;
  logic              flush;
  logic [3:0]        id_cond;
  logic              id_s;
  logic [3:0]        status_reg;
  logic [3:0]        status_fwd;
  logic              flag_stall;

  modport slave (
    input  exe_valid, exe_cond_pass, exe_s, exe_op_class, exe_result,
           exe_carry, exe_overflow, mul_res_valid, mul_result, flush,
           id_cond, id_s,
    output status_reg, status_fwd, flag_stall
  );

  modport master (
    output exe_valid, exe_cond_pass, exe_s, exe_op_class, exe_result,
           exe_carry, exe_overflow, mul_res_valid, mul_result, flush,
           id_cond, id_s,
    input  status_reg, status_fwd, flag_stall
  );
endinterface

// File: rtl/status_flag_unit_flag_gen.sv
// Combinational NZCV generator.
//   result    : ALU or multiplier result selected by the caller
//   carry     : ALU carry-out / shifter carry
//   overflow  : ALU signed overflow
//   op_class  : operation class (logical/add/sub/mul)
//   flags_in  : current {N,Z,C,V}, source of the unchanged bits
//   flags_out : new {N,Z,C,V}
module flag_gen
  import status_flag_unit_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] result,
  input  logic              carry,
  input  logic              overflow,
  input  logic [1:0]        op_class,
  input  logic [3:0]        flags_in,
  output logic [3:0]        flags_out
);

  always_comb begin
    flags_out         = flags_in;
    flags_out[FLAG_N] = result[DATA_W-1];
    flags_out[FLAG_Z] = ~|result;
    case (op_class)
      OP_LOGIC: flags_out[FLAG_C] = carry;
      OP_ADD, OP_SUB: begin
        flags_out[FLAG_C] = carry;
        flags_out[FLAG_V] = overflow;
      end
      default: ; // multiply: C and V keep their previous values
    endcase
  end

endmodule

// File: rtl/status_flag_unit.sv
// Producer side of the NZCV status interface. Holds the status register,
// updates it from EXE ALU results or from the multi-cycle multiplier, offers
// a same-cycle bypass view and stalls ID while a flag-setting multiply is
// outstanding.
//   clk   : clock, rising edge
//   rst_n : asynchronous reset, active low
//   bus   : status_flag_unit_if.slave (EXE/multiplier/ID inputs,
//           status_reg / status_fwd / flag_stall outputs)
module status_flag_unit
  import status_flag_unit_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  status_flag_unit_if.slave      bus
);

  state_t            state;
  logic              upd;
  logic              flag_upd;
  logic              go_mul;
  logic [DATA_W-1:0] sel_result;
  logic [1:0]        sel_class;
  logic [3:0]        gen_flags;

  // While waiting on the multiplier the single generator is fed the
  // multiplier result and told it is a multiply, so C/V are preserved.
  always_comb begin
    if (state == MUL_WAIT) begin
      sel_result = bus.mul_result;
      sel_class  = OP_MUL;
    end else begin
      sel_result = bus.exe_result;
      sel_class  = bus.exe_op_class;
    end
  end

  flag_gen #(.DATA_W(DATA_W)) u_flag_gen (
    .result    (sel_result),
    .carry     (bus.exe_carry),
    .overflow  (bus.exe_overflow),
    .op_class  (sel_class),
    .flags_in  (bus.status_reg),
    .flags_out (gen_flags)
  );

  always_comb begin
    upd      = bus.exe_valid & bus.exe_cond_pass & bus.exe_s & ~bus.flush;
    flag_upd = 1'b0;
    go_mul   = 1'b0;
    case (state)
      IDLE: begin
        flag_upd = upd & (bus.exe_op_class != OP_MUL);
        go_mul   = upd & (bus.exe_op_class == OP_MUL);
      end
      MUL_WAIT: flag_upd = bus.mul_res_valid & ~bus.flush;
      default: ;
    endcase
  end

  always_comb begin
    bus.status_fwd = flag_upd ? gen_flags : bus.status_reg;
    // Released as soon as the result arrives: status_fwd already carries it.
    bus.flag_stall = (state == MUL_WAIT) & ~bus.mul_res_valid &
                     ((bus.id_cond != COND_AL) | bus.id_s);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      bus.status_reg <= '0;
    end else begin
      if (flag_upd) bus.status_reg <= gen_flags;
      case (state)
        IDLE:     if (go_mul) state <= MUL_WAIT;
        MUL_WAIT: if (bus.flush || bus.mul_res_valid) state <= IDLE;
        default:  state <= IDLE;
      endcase
    end
  end

endmodule
